// File: rtl/score_keeper.sv
// ============================================================================
// Module   : score_keeper
// Purpose  : Two-player BCD score accumulator and level sequencer with
//            frame-latched display shadows.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper #(
  parameter int MAX_LEVEL    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_end,
  input  logic       hit_p1,
  input  logic       hit_p2,
  input  logic [3:0] pts_p1,
  input  logic [3:0] pts_p2,
  input  logic       level_clear,
  input  logic       game_restart,
  output logic [9:0] level,
  output logic [9:0] score,
  output logic [9:0] score_tens,
  output logic [9:0] score_hundreds,
  output logic [9:0] score2,
  output logic [9:0] score2_tens,
  output logic [9:0] score2_hundreds,
  output logic       level_paused,
  output logic       game_won
);

  localparam logic [1:0] c_PLAY  = 2'd0;
  localparam logic [1:0] c_PAUSE = 2'd1;
  localparam logic [1:0] c_WON   = 2'd2;

  localparam int             c_CNT_W = $clog2(PAUSE_FRAMES + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PAUSE_FRAMES - 1);
  localparam logic [3:0]     c_MAX   = 4'(MAX_LEVEL);

  // Adds one clamped hit value to a packed {hundreds, tens, ones} BCD score,
  // saturating at 999 instead of wrapping.
  function automatic logic [11:0] bcd_add(input logic [11:0] d, input logic [3:0] pts);
    logic [3:0] p;
    logic [4:0] s;
    logic [3:0] o;
    logic [3:0] t;
    logic [3:0] h;
    logic       c1;
    logic       c2;
    p  = (pts > 4'd9) ? 4'd9 : pts;
    s  = {1'b0, d[3:0]} + {1'b0, p};
    c1 = (s >= 5'd10);
    o  = c1 ? 4'(s - 5'd10) : s[3:0];
    t  = d[7:4] + {3'b000, c1};
    c2 = (t == 4'd10);
    if (c2) t = 4'd0;
    h  = d[11:8] + {3'b000, c2};
    if (h == 4'd10) bcd_add = 12'h999;
    else            bcd_add = {h, t, o};
  endfunction

  logic [11:0]        r_p1;
  logic [11:0]        r_p2;
  logic [11:0]        r_p1_shadow;
  logic [11:0]        r_p2_shadow;
  logic [3:0]         r_level;
  logic [3:0]         r_level_shadow;
  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_paused;
  logic               r_won;

  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [3:0]         w_level_nxt;
  logic [11:0]        w_p1_nxt;
  logic [11:0]        w_p2_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    case (r_state)
      c_PLAY: begin
        if (level_clear) begin
          if (r_level < c_MAX) begin
            w_state_nxt = c_PAUSE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = c_WON;
          end
        end
      end
      c_PAUSE: begin
        if (frame_end) begin
          if (r_cnt == c_LAST) begin
            w_cnt_nxt   = '0;
            w_level_nxt = r_level + 4'd1;
            w_state_nxt = c_PLAY;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_p1_nxt = (r_state == c_PLAY && hit_p1) ? bcd_add(r_p1, pts_p1) : r_p1;
  assign w_p2_nxt = (r_state == c_PLAY && hit_p2) ? bcd_add(r_p2, pts_p2) : r_p2;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      r_p1           <= '0;
      r_p2           <= '0;
      r_p1_shadow    <= '0;
      r_p2_shadow    <= '0;
      r_level        <= 4'd1;
      r_level_shadow <= 4'd1;
      r_state        <= c_PLAY;
      r_cnt          <= '0;
      r_paused       <= 1'b0;
      r_won          <= 1'b0;
    end else if (game_restart) begin
      r_p1           <= '0;
      r_p2           <= '0;
      r_p1_shadow    <= '0;
      r_p2_shadow    <= '0;
      r_level        <= 4'd1;
      r_level_shadow <= 4'd1;
      r_state        <= c_PLAY;
      r_cnt          <= '0;
      r_paused       <= 1'b0;
      r_won          <= 1'b0;
    end else begin
      r_p1     <= w_p1_nxt;
      r_p2     <= w_p2_nxt;
      r_level  <= w_level_nxt;
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_paused <= (w_state_nxt == c_PAUSE);
      r_won    <= (w_state_nxt == c_WON);
      // Shadows take the pre-edge values so a coincident event shows next frame.
      if (frame_end) begin
        r_p1_shadow    <= r_p1;
        r_p2_shadow    <= r_p2;
        r_level_shadow <= r_level;
      end
    end
  end

  assign level           = {6'b0, r_level_shadow};
  assign score           = {6'b0, r_p1_shadow[3:0]};
  assign score_tens      = {6'b0, r_p1_shadow[7:4]};
  assign score_hundreds  = {6'b0, r_p1_shadow[11:8]};
  assign score2          = {6'b0, r_p2_shadow[3:0]};
  assign score2_tens     = {6'b0, r_p2_shadow[7:4]};
  assign score2_hundreds = {6'b0, r_p2_shadow[11:8]};
  assign level_paused    = r_paused;
  assign game_won        = r_won;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// Module   : tb_score_keeper
// Purpose  : Randomized self-checking bench for score_keeper against an
//            integer-arithmetic game model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

  localparam int MAX_LEVEL    = 3;
  localparam int PAUSE_FRAMES = 3;

  logic       vga_clk;
  logic       Reset;
  logic       frame_end;
  logic       hit_p1;
  logic       hit_p2;
  logic [3:0] pts_p1;
  logic [3:0] pts_p2;
  logic       level_clear;
  logic       game_restart;
  logic [9:0] level;
  logic [9:0] score;
  logic [9:0] score_tens;
  logic [9:0] score_hundreds;
  logic [9:0] score2;
  logic [9:0] score2_tens;
  logic [9:0] score2_hundreds;
  logic       level_paused;
  logic       game_won;

  score_keeper #(.MAX_LEVEL(MAX_LEVEL), .PAUSE_FRAMES(PAUSE_FRAMES)) dut (
    .vga_clk        (vga_clk),
    .Reset          (Reset),
    .frame_end      (frame_end),
    .hit_p1         (hit_p1),
    .hit_p2         (hit_p2),
    .pts_p1         (pts_p1),
    .pts_p2         (pts_p2),
    .level_clear    (level_clear),
    .game_restart   (game_restart),
    .level          (level),
    .score          (score),
    .score_tens     (score_tens),
    .score_hundreds (score_hundreds),
    .score2         (score2),
    .score2_tens    (score2_tens),
    .score2_hundreds(score2_hundreds),
    .level_paused   (level_paused),
    .game_won       (game_won)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int checks   = 0;
  int failures = 0;

  // Game model: scores are plain integers, mode 0=play 1=pause 2=won.
  int m_s1, m_s2, m_lvl, m_mode, m_cnt;
  int d_s1, d_s2, d_lvl;
  bit m_paused, m_won;

  logic [71:0] obs;
  logic [71:0] expv;
  assign obs = {level, score_hundreds, score_tens, score, score2_hundreds,
                score2_tens, score2, level_paused, game_won};

  function automatic int clamp9(input logic [3:0] p);
    return (p > 4'd9) ? 9 : int'(p);
  endfunction

  function automatic logic [71:0] model_vec();
    return {10'(d_lvl), 10'(d_s1 / 100), 10'((d_s1 / 10) % 10), 10'(d_s1 % 10),
            10'(d_s2 / 100), 10'((d_s2 / 10) % 10), 10'(d_s2 % 10), m_paused, m_won};
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 1; m_mode = 0; m_cnt = 0;
    d_s1 = 0; d_s2 = 0; d_lvl = 1; m_paused = 0; m_won = 0;
  endtask

  task automatic model_edge();
    int old_mode;
    if (game_restart) begin
      model_reset();
      return;
    end
    if (frame_end) begin
      d_s1 = m_s1; d_s2 = m_s2; d_lvl = m_lvl;
    end
    old_mode = m_mode;
    if (old_mode == 0) begin
      if (hit_p1) m_s1 = (m_s1 + clamp9(pts_p1) > 999) ? 999 : m_s1 + clamp9(pts_p1);
      if (hit_p2) m_s2 = (m_s2 + clamp9(pts_p2) > 999) ? 999 : m_s2 + clamp9(pts_p2);
      if (level_clear) begin
        if (m_lvl < MAX_LEVEL) begin m_mode = 1; m_cnt = 0; end
        else m_mode = 2;
      end
    end else if (old_mode == 1 && frame_end) begin
      m_cnt++;
      if (m_cnt == PAUSE_FRAMES) begin m_lvl++; m_mode = 0; m_cnt = 0; end
    end
    m_paused = (m_mode == 1);
    m_won    = (m_mode == 2);
  endtask

  task automatic clear_inputs();
    frame_end = 0; hit_p1 = 0; hit_p2 = 0; pts_p1 = 0; pts_p2 = 0;
    level_clear = 0; game_restart = 0;
  endtask

  // One clock with the currently driven inputs; pulses drop after the edge.
  task automatic cycle();
    @(posedge vga_clk);
    model_edge();
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    Reset = 1; clear_inputs(); model_reset();
    repeat (2) @(posedge vga_clk);
    #1 Reset = 0;
    expv = model_vec();
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL reset_state got=%h want=%h", obs, expv); end
    frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL reset_frame got=%h want=%h", obs, expv); end
  endtask

  task automatic test_hit_seq();
    hit_p1 = 1; pts_p1 = 7; cycle();
    hit_p1 = 1; pts_p1 = 5; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || score !== 10'd0) begin failures++; $display("FAIL hit_before_frame got=%h want=%h", obs, expv); end
    frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || score !== 10'd2 || score_tens !== 10'd1 || score2 !== 10'd0) begin
      failures++; $display("FAIL hit_seq_12 got=%h want=%h", obs, expv);
    end
    hit_p1 = 1; pts_p1 = 4'd15; cycle();
    frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || score !== 10'd1 || score_tens !== 10'd2) begin
      failures++; $display("FAIL hit_clamp got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      hit_p1       = ($urandom_range(0, 1) == 1);
      hit_p2       = ($urandom_range(0, 1) == 1);
      pts_p1       = 4'($urandom_range(0, 15));
      pts_p2       = 4'($urandom_range(0, 15));
      frame_end    = ($urandom_range(0, 3) == 0);
      level_clear  = ($urandom_range(0, 29) == 0);
      game_restart = ($urandom_range(0, 99) == 0);
      cycle();
      expv = model_vec();
      checks++;
      if (obs !== expv) begin
        failures++; errs++;
        if (errs < 5) $display("FAIL random_cycle_%0d got=%h want=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_saturation();
    game_restart = 1; cycle();
    while (m_s2 + 9 <= 998) begin hit_p2 = 1; pts_p2 = 9; cycle(); end
    if (m_s2 < 998) begin hit_p2 = 1; pts_p2 = 4'(998 - m_s2); cycle(); end
    hit_p1 = 1; pts_p1 = 4; cycle();
    frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || score2_hundreds !== 10'd9 || score2 !== 10'd8) begin
      failures++; $display("FAIL preload_998 got=%h want=%h", obs, expv);
    end
    hit_p2 = 1; pts_p2 = 9; hit_p1 = 1; pts_p1 = 3; cycle();
    frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || {score2_hundreds, score2_tens, score2} !== {10'd9, 10'd9, 10'd9} || score !== 10'd7) begin
      failures++; $display("FAIL saturate_simul got=%h want=%h", obs, expv);
    end
    hit_p2 = 1; pts_p2 = 9; cycle();
    frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL saturate_hold got=%h want=%h", obs, expv); end
  endtask

  task automatic test_pause();
    level_clear = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || level_paused !== 1'b1) begin failures++; $display("FAIL pause_enter got=%h want=%h", obs, expv); end
    hit_p1 = 1; pts_p1 = 9; level_clear = 1; cycle();
    for (int f = 0; f < PAUSE_FRAMES; f++) begin
      cycle();
      frame_end = 1; cycle();
    end
    expv = model_vec();
    checks++;
    if (obs !== expv || level_paused !== 1'b0 || level !== 10'd1 || score !== 10'd7) begin
      failures++; $display("FAIL pause_exit got=%h want=%h", obs, expv);
    end
    frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || level !== 10'd2) begin failures++; $display("FAIL level_advance got=%h want=%h", obs, expv); end
  endtask

  task automatic test_win();
    level_clear = 1; cycle();
    for (int f = 0; f < PAUSE_FRAMES; f++) begin frame_end = 1; cycle(); end
    frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || level !== 10'd3) begin failures++; $display("FAIL reach_max got=%h want=%h", obs, expv); end
    level_clear = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || game_won !== 1'b1) begin failures++; $display("FAIL win_enter got=%h want=%h", obs, expv); end
    hit_p1 = 1; pts_p1 = 5; hit_p2 = 1; pts_p2 = 5; level_clear = 1; cycle();
    frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || score !== 10'd7) begin failures++; $display("FAIL win_ignore got=%h want=%h", obs, expv); end
    game_restart = 1; hit_p1 = 1; pts_p1 = 6; frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || game_won !== 1'b0 || level !== 10'd1 || score !== 10'd0 || score2_hundreds !== 10'd0) begin
      failures++; $display("FAIL restart_clear got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_async_reset();
    hit_p1 = 1; pts_p1 = 8; hit_p2 = 1; pts_p2 = 6; cycle();
    frame_end = 1; cycle();
    level_clear = 1; cycle();
    frame_end = 1; cycle();
    @(posedge vga_clk);
    #2 Reset = 1;
    #1 model_reset();
    expv = model_vec();
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL async_reset_now got=%h want=%h", obs, expv); end
    @(posedge vga_clk);
    #1 Reset = 0;
    level_clear = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || level_paused !== 1'b1) begin failures++; $display("FAIL after_reset_play got=%h want=%h", obs, expv); end
    for (int f = 0; f < PAUSE_FRAMES; f++) begin frame_end = 1; cycle(); end
    frame_end = 1; cycle();
    expv = model_vec();
    checks++;
    if (obs !== expv || level !== 10'd2) begin failures++; $display("FAIL after_reset_count got=%h want=%h", obs, expv); end
  endtask

  initial begin
    Reset = 1;
    clear_inputs();
    model_reset();
    test_reset();
    test_hit_seq();
    test_random();
    test_saturation();
    test_pause();
    test_win();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/score_keeper.md
# score_keeper

Per-player BCD score accumulator and level sequencer for the two-player game. It sits directly upstream of the level/score text overlay and drives the `level`, `score`/`score_tens`/`score_hundreds` and `score2`/`score2_tens`/`score2_hundreds` digit inputs that overlay renders. Internal counters update on game events. Display-facing outputs are shadow registers that reload only at frame boundaries, so digits never change mid-scan.

## Interface
Parameters:
- `MAX_LEVEL`, 9: last playable level. Must be 1..9, because the overlay renders a single digit.
- `PAUSE_FRAMES`, 60: number of frames held in the inter-level pause.

Ports:
- `vga_clk` input 1: pixel clock; the only clock.
- `Reset` input 1: asynchronous, active-high reset.
- `frame_end` input 1: one-cycle pulse per frame, asserted during vertical blank.
- `hit_p1`, `hit_p2` input 1 each: one-cycle pulse when that player pops a bubble.
- `pts_p1`, `pts_p2` input 4 each: points for the matching hit. Legal range 0..9; values above 9 are clamped to 9.
- `level_clear` input 1: one-cycle pulse when all bubbles are gone.
- `game_restart` input 1: one-cycle pulse that returns the block to its initial state.
- `level` output 10: displayed level digit, 1..MAX_LEVEL.
- `score`, `score_tens`, `score_hundreds` output 10 each: player-1 displayed BCD digits. Values 0..9; bits [9:4] are always 0.
- `score2`, `score2_tens`, `score2_hundreds` output 10 each: player-2 displayed digits, same encoding as player 1.
- `level_paused` output 1: high while in PAUSE.
- `game_won` output 1: high while in WON.

## Operation
Internal state per player:
- Three BCD digit registers (ones, tens, hundreds).
- Shadow copies of those digits feed the outputs.
- The level has its own internal register and shadow copy.

Hit addition, performed when `hit_pX` is high and the FSM is in PLAY:
- Compute `s = ones + min(pts,9)`.
- If `s >= 10`: ones = s-10, carry = 1 into tens.
- If tens+carry equals 10: tens = 0 and carry into hundreds.
- If hundreds would reach 10: saturate the whole score to 9/9/9. There is no wrap.
- Both players may hit in the same cycle; each player's addition is independent.

Level FSM states are PLAY, PAUSE and WON.
- PLAY + `level_clear`:
  - If level < MAX_LEVEL: go to PAUSE and clear the frame counter.
  - If level == MAX_LEVEL: go to WON.
- PAUSE:
  - Each `frame_end` increments the frame counter.
  - On the `frame_end` that makes the count equal PAUSE_FRAMES: level += 1 and go to PLAY.
  - Hits are ignored.
- WON: hits and `level_clear` are ignored. The FSM holds until `game_restart`.
- `level_clear` in PAUSE or WON is ignored.

`game_restart`, any state:
- Scores are set to 0, level to 1 and the state to PLAY.
- Restart has priority over a hit or `level_clear` in the same cycle.
- The shadow registers are also cleared in the same cycle, so the display changes immediately.

Display latch: on each edge where `frame_end` is high, all shadow registers load the internal values as they were before that edge. An event coinciding with `frame_end` therefore appears at the following frame.

## Timing
Reset values (asynchronous, immediate):
- All digit outputs 0, `level` = 1.
- State PLAY, frame counter 0.
- `level_paused` = 0, `game_won` = 0.

Latencies:
- Hit to internal digits: 1 cycle.
- Internal to output: up to one frame, taken at the next `frame_end`.
- `level_paused` and `game_won` are registered from the state and assert the cycle after the transition. They are not frame-latched.
- `level` increments in the internal register on the final pause `frame_end`. The output shows the new value at the next `frame_end`, and state is PLAY in the meantime.

Other timing rules:
- Reset asserted mid-pause or mid-addition discards the operation with no partial update.
- Pulse inputs are sampled every cycle. A held-high `hit_pX` adds once per cycle and is not edge-detected.

## Test plan
1. Reset, then apply `frame_end` → all scores 0/0/0, `level`=1, `level_paused`=0, `game_won`=0.
2. Hit sequence on player 1:
   - P1 hit pts=7, then pts=5, then `frame_end` → outputs ones=2, tens=1, hundreds=0.
   - Player-2 outputs stay 0.
   - Before that `frame_end`, the outputs still show 0.
3. Saturation and simultaneous hits:
   - Preload P2 to 998 via hits, then hit pts=9 and apply `frame_end` → P2 output 9/9/9.
   - In the same cycle as a P1 hit pts=3 → P1 ones +3, with no interaction between players.
4. Pause and level advance, with PAUSE_FRAMES=3:
   - `level_clear` → `level_paused`=1 on the next cycle.
   - A hit during the pause leaves the score unchanged.
   - After 3 `frame_end` pulses → state PLAY, and `level`=2 on the following `frame_end`.
5. Win and restart:
   - At level MAX_LEVEL, `level_clear` → `game_won`=1, and subsequent hits are ignored.
   - `game_restart` in the same cycle as `hit_p1` → scores 0, `level`=1, `game_won`=0, with outputs cleared immediately.
6. Asynchronous reset asserted mid-PAUSE, between clock edges → outputs reset immediately. After release, the FSM is in PLAY with `level`=1.
